// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline run controller: FSM encodings,
// drain depth default and the ID/EX mem_signals layout.
package pipeline_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  // EX -> MEM -> WB retire of the halt instruction
  localparam int N_DRAIN_DEFAULT = 3;

  // Position of the memory-read bit inside ID/EX mem_signals_o
  localparam int MEM_SIG_READ_BIT = 1;

  function automatic logic state_enables(input state_t s);
    return (s == ST_RUN) || (s == ST_STEP) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/pipeline_run_controller_load_use.sv
// Combinational load-use hazard detector: a load in EX whose destination
// is read by the instruction currently in ID.
module load_use_detector #(
  parameter int NB_REG = 5
) (
  input  logic              ex_mem_read_i,
  input  logic [NB_REG-1:0] ex_register_rw_i,
  input  logic [NB_REG-1:0] id_register_a_i,
  input  logic [NB_REG-1:0] id_register_b_i,
  input  logic              id_uses_rb_i,
  output logic              load_use_o
);

  logic rw_nonzero;
  logic hit_a;
  logic hit_b;

  // Register 0 is hardwired to zero, so a load into it never creates a hazard
  assign rw_nonzero = (ex_register_rw_i != '0);
  assign hit_a      = (ex_register_rw_i == id_register_a_i);
  assign hit_b      = id_uses_rb_i && (ex_register_rw_i == id_register_b_i);
  assign load_use_o = ex_mem_read_i && rw_nonzero && (hit_a || hit_b);

endmodule

// File: rtl/pipeline_run_controller.sv
// IDLE/RUN/STEP/DRAIN/HALTED execution control with load-use stall/bubble
// generation. Optional breakpoint support with PIPE_BREAKPOINT_EN.
module pipeline_run_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int NB_REG  = 5,
  parameter int NB_DATA = 32,
  parameter int N_DRAIN = N_DRAIN_DEFAULT
) (
  input  logic               clock,
  input  logic               reset_i,
  input  logic               cmd_run_i,
  input  logic               cmd_step_i,
  input  logic               cmd_stop_i,
  input  logic               halt_id_i,
  input  logic               halt_ex_i,
  input  logic               ex_mem_read_i,
  input  logic [NB_REG-1:0]  ex_register_rw_i,
  input  logic [NB_REG-1:0]  id_register_a_i,
  input  logic [NB_REG-1:0]  id_register_b_i,
  input  logic               id_uses_rb_i,
`ifdef PIPE_BREAKPOINT_EN
  input  logic               bp_valid_i,
  input  logic [NB_DATA-1:0] bp_pc_i,
  input  logic [NB_DATA-1:0] id_pc_i,
`endif
  output logic               en_pipeline_o,
  output logic               stall_if_id_o,
  output logic               bubble_id_ex_o,
  output logic               pc_hold_o,
  output logic               halted_o,
  output logic               step_done_o,
  output logic [2:0]         state_o,
  output logic [NB_DATA-1:0] cycle_count_o
);

  localparam int NB_CNT = (N_DRAIN > 1) ? $clog2(N_DRAIN) : 1;
  localparam logic [NB_CNT-1:0] DRAIN_LOAD = NB_CNT'(N_DRAIN - 1);

  state_t             state;
  state_t             state_next;
  logic [NB_CNT-1:0]  drain_cnt;
  logic [NB_CNT-1:0]  drain_cnt_next;
  logic               en_q;
  logic               en_next;
  logic               halted_q;
  logic               halted_next;
  logic               step_done_q;
  logic               step_done_next;
  logic               pc_hold_q;
  logic [NB_DATA-1:0] cycle_cnt;
  logic               load_use;
  logic               bp_hit;

  load_use_detector #(
    .NB_REG (NB_REG)
  ) u_load_use (
    .ex_mem_read_i    (ex_mem_read_i),
    .ex_register_rw_i (ex_register_rw_i),
    .id_register_a_i  (id_register_a_i),
    .id_register_b_i  (id_register_b_i),
    .id_uses_rb_i     (id_uses_rb_i),
    .load_use_o       (load_use)
  );

`ifdef PIPE_BREAKPOINT_EN
  assign bp_hit = bp_valid_i && (id_pc_i == bp_pc_i);
`else
  assign bp_hit = 1'b0;
`endif

  // Commands are single-cycle pulses sampled on posedge; no handshake back,
  // a pulse that arrives in a state that ignores it is simply dropped.
  always_ff @(posedge clock or negedge reset_i) begin
    if (!reset_i) begin
      state       <= ST_IDLE;
      drain_cnt   <= '0;
      en_q        <= 1'b0;
      halted_q    <= 1'b0;
      step_done_q <= 1'b0;
    end else begin
      state       <= state_next;
      drain_cnt   <= drain_cnt_next;
      en_q        <= en_next;
      halted_q    <= halted_next;
      step_done_q <= step_done_next;
    end
  end

  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    case (state)
      ST_IDLE: begin
        if (cmd_run_i)       state_next = ST_RUN;
        else if (cmd_step_i) state_next = ST_STEP;
      end
      ST_RUN: begin
        if (halt_ex_i) begin
          state_next     = ST_DRAIN;
          drain_cnt_next = DRAIN_LOAD;
        end else if (bp_hit || cmd_stop_i) begin
          state_next = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (halt_ex_i) begin
          state_next     = ST_DRAIN;
          drain_cnt_next = DRAIN_LOAD;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == '0) state_next = ST_HALTED;
        else                 drain_cnt_next = drain_cnt - 1'b1;
      end
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state and registered, so they are
  // clean Moore outputs aligned with state_o.
  always_comb begin
    en_next        = state_enables(state_next);
    halted_next    = (state_next == ST_HALTED);
    step_done_next = (state == ST_STEP) && (state_next == ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset_i) begin
    if (!reset_i) begin
      pc_hold_q <= 1'b0;
    end else if (halt_id_i && en_q && !load_use) begin
      pc_hold_q <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_i) begin
    if (!reset_i) begin
      cycle_cnt <= '0;
    end else if (en_q && (cycle_cnt != '1)) begin
      cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

  assign en_pipeline_o  = en_q;
  assign stall_if_id_o  = load_use && en_q;
  assign bubble_id_ex_o = load_use && en_q;
  assign pc_hold_o      = pc_hold_q;
  assign halted_o       = halted_q;
  assign step_done_o    = step_done_q;
  assign state_o        = state;
  assign cycle_count_o  = cycle_cnt;

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Directed bench for pipeline_run_controller: load-use table plus
// hand-written FSM sequences, with a 4-bit counter instance for saturation.
module tb_pipeline_run_controller;

  logic        clock;
  logic        reset_i;
  logic        cmd_run_i;
  logic        cmd_step_i;
  logic        cmd_stop_i;
  logic        halt_id_i;
  logic        halt_ex_i;
  logic        ex_mem_read_i;
  logic [4:0]  ex_register_rw_i;
  logic [4:0]  id_register_a_i;
  logic [4:0]  id_register_b_i;
  logic        id_uses_rb_i;

  logic        en_pipeline;
  logic        stall_if_id;
  logic        bubble_id_ex;
  logic        pc_hold;
  logic        halted;
  logic        step_done;
  logic [2:0]  state;
  logic [31:0] cycle_count;

  logic        en4;
  logic        stall4;
  logic        bubble4;
  logic        pc_hold4;
  logic        halted4;
  logic        step_done4;
  logic [2:0]  state4;
  logic [3:0]  cycle_count4;

  int          checks;
  int          errors;
  int          exp_cnt;
  logic        exp_en;

  typedef struct {
    logic       mr;
    logic [4:0] rw;
    logic [4:0] a;
    logic [4:0] b;
    logic       rb;
    logic       exp_stall;
  } lu_vec_t;

  lu_vec_t lu_tab[8];

  pipeline_run_controller dut (
    .clock            (clock),
    .reset_i          (reset_i),
    .cmd_run_i        (cmd_run_i),
    .cmd_step_i       (cmd_step_i),
    .cmd_stop_i       (cmd_stop_i),
    .halt_id_i        (halt_id_i),
    .halt_ex_i        (halt_ex_i),
    .ex_mem_read_i    (ex_mem_read_i),
    .ex_register_rw_i (ex_register_rw_i),
    .id_register_a_i  (id_register_a_i),
    .id_register_b_i  (id_register_b_i),
    .id_uses_rb_i     (id_uses_rb_i),
`ifdef PIPE_BREAKPOINT_EN
    .bp_valid_i       (1'b0),
    .bp_pc_i          (32'd0),
    .id_pc_i          (32'd0),
`endif
    .en_pipeline_o    (en_pipeline),
    .stall_if_id_o    (stall_if_id),
    .bubble_id_ex_o   (bubble_id_ex),
    .pc_hold_o        (pc_hold),
    .halted_o         (halted),
    .step_done_o      (step_done),
    .state_o          (state),
    .cycle_count_o    (cycle_count)
  );

  pipeline_run_controller #(.NB_DATA(4)) dut4 (
    .clock            (clock),
    .reset_i          (reset_i),
    .cmd_run_i        (cmd_run_i),
    .cmd_step_i       (cmd_step_i),
    .cmd_stop_i       (cmd_stop_i),
    .halt_id_i        (halt_id_i),
    .halt_ex_i        (halt_ex_i),
    .ex_mem_read_i    (ex_mem_read_i),
    .ex_register_rw_i (ex_register_rw_i),
    .id_register_a_i  (id_register_a_i),
    .id_register_b_i  (id_register_b_i),
    .id_uses_rb_i     (id_uses_rb_i),
`ifdef PIPE_BREAKPOINT_EN
    .bp_valid_i       (1'b0),
    .bp_pc_i          (4'd0),
    .id_pc_i          (4'd0),
`endif
    .en_pipeline_o    (en4),
    .stall_if_id_o    (stall4),
    .bubble_id_ex_o   (bubble4),
    .pc_hold_o        (pc_hold4),
    .halted_o         (halted4),
    .step_done_o      (step_done4),
    .state_o          (state4),
    .cycle_count_o    (cycle_count4)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected count advances on every edge where the expected enable was high
  task automatic tick();
    if (exp_en) exp_cnt++;
    @(posedge clock);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [2:0] s);
    exp_en = (s == 3'd1) || (s == 3'd2) || (s == 3'd3);
    chk({tag, "_state"}, 32'(state), 32'(s));
    chk({tag, "_en"}, 32'(en_pipeline), 32'(exp_en));
    chk({tag, "_halted"}, 32'(halted), 32'(s == 3'd4));
    chk({tag, "_count"}, cycle_count, 32'(exp_cnt));
  endtask

  task automatic clear_inputs();
    cmd_run_i        = 1'b0;
    cmd_step_i       = 1'b0;
    cmd_stop_i       = 1'b0;
    halt_id_i        = 1'b0;
    halt_ex_i        = 1'b0;
    ex_mem_read_i    = 1'b0;
    ex_register_rw_i = 5'd0;
    id_register_a_i  = 5'd0;
    id_register_b_i  = 5'd0;
    id_uses_rb_i     = 1'b0;
  endtask

  task automatic apply_reset();
    reset_i = 1'b0;
    #1;
    exp_cnt = 0;
    exp_en  = 1'b0;
    @(posedge clock);
    #1;
    reset_i = 1'b1;
  endtask

  initial begin
    lu_tab[0] = '{mr: 1'b1, rw: 5'd5,  a: 5'd5,  b: 5'd0, rb: 1'b0, exp_stall: 1'b1};
    lu_tab[1] = '{mr: 1'b1, rw: 5'd0,  a: 5'd0,  b: 5'd0, rb: 1'b1, exp_stall: 1'b0};
    lu_tab[2] = '{mr: 1'b1, rw: 5'd5,  a: 5'd0,  b: 5'd5, rb: 1'b0, exp_stall: 1'b0};
    lu_tab[3] = '{mr: 1'b1, rw: 5'd5,  a: 5'd0,  b: 5'd5, rb: 1'b1, exp_stall: 1'b1};
    lu_tab[4] = '{mr: 1'b0, rw: 5'd5,  a: 5'd5,  b: 5'd5, rb: 1'b1, exp_stall: 1'b0};
    lu_tab[5] = '{mr: 1'b1, rw: 5'd7,  a: 5'd3,  b: 5'd4, rb: 1'b1, exp_stall: 1'b0};
    lu_tab[6] = '{mr: 1'b1, rw: 5'd31, a: 5'd31, b: 5'd2, rb: 1'b0, exp_stall: 1'b1};
    lu_tab[7] = '{mr: 1'b1, rw: 5'd9,  a: 5'd1,  b: 5'd9, rb: 1'b1, exp_stall: 1'b1};

    checks  = 0;
    errors  = 0;
    exp_cnt = 0;
    exp_en  = 1'b0;
    clear_inputs();
    reset_i = 1'b0;

    // reset values
    repeat (2) @(posedge clock);
    #1;
    expect_state("reset", 3'd0);
    chk("reset_step_done", 32'(step_done), 32'd0);
    chk("reset_pc_hold", 32'(pc_hold), 32'd0);
    chk("reset_stall", 32'(stall_if_id), 32'd0);
    reset_i = 1'b1;
    tick();
    tick();
    expect_state("idle_no_cmd", 3'd0);

    // single step
    cmd_step_i = 1'b1;
    tick();
    cmd_step_i = 1'b0;
    expect_state("step", 3'd2);
    chk("step_done_during_step", 32'(step_done), 32'd0);
    tick();
    expect_state("after_step", 3'd0);
    chk("step_done_pulse", 32'(step_done), 32'd1);
    tick();
    expect_state("after_step2", 3'd0);
    chk("step_done_cleared", 32'(step_done), 32'd0);

    // free run and load-use table
    cmd_run_i = 1'b1;
    tick();
    cmd_run_i = 1'b0;
    expect_state("run", 3'd1);
    for (int i = 0; i < 8; i++) begin
      ex_mem_read_i    = lu_tab[i].mr;
      ex_register_rw_i = lu_tab[i].rw;
      id_register_a_i  = lu_tab[i].a;
      id_register_b_i  = lu_tab[i].b;
      id_uses_rb_i     = lu_tab[i].rb;
      #1;
      chk($sformatf("lu_stall_%0d", i), 32'(stall_if_id), 32'(lu_tab[i].exp_stall));
      chk($sformatf("lu_bubble_%0d", i), 32'(bubble_id_ex), 32'(lu_tab[i].exp_stall));
    end
    clear_inputs();
    cmd_step_i = 1'b1;
    tick();
    cmd_step_i = 1'b0;
    expect_state("run_ignores_step", 3'd1);

    // pc_hold: blocked by load-use, then sticky
    halt_id_i        = 1'b1;
    ex_mem_read_i    = 1'b1;
    ex_register_rw_i = 5'd5;
    id_register_a_i  = 5'd5;
    tick();
    chk("pc_hold_blocked", 32'(pc_hold), 32'd0);
    ex_mem_read_i = 1'b0;
    tick();
    chk("pc_hold_set", 32'(pc_hold), 32'd1);
    halt_id_i = 1'b0;
    tick();
    chk("pc_hold_sticky", 32'(pc_hold), 32'd1);
    while (exp_cnt < 7) tick();
    expect_state("run_cnt7", 3'd1);

    // reset mid-run with a live hazard pattern on the inputs
    ex_mem_read_i = 1'b1;
    reset_i = 1'b0;
    #1;
    exp_cnt = 0;
    expect_state("mid_reset", 3'd0);
    chk("mid_reset_stall", 32'(stall_if_id), 32'd0);
    chk("mid_reset_bubble", 32'(bubble_id_ex), 32'd0);
    chk("mid_reset_pc_hold", 32'(pc_hold), 32'd0);
    chk("mid_reset_step_done", 32'(step_done), 32'd0);
    @(posedge clock);
    #1;
    reset_i = 1'b1;
    clear_inputs();
    tick();
    tick();
    expect_state("post_reset_idle", 3'd0);

    // run beats step; stop alone; halt beats stop
    cmd_run_i  = 1'b1;
    cmd_step_i = 1'b1;
    tick();
    cmd_run_i  = 1'b0;
    cmd_step_i = 1'b0;
    expect_state("run_wins", 3'd1);
    cmd_stop_i = 1'b1;
    tick();
    cmd_stop_i = 1'b0;
    expect_state("stop", 3'd0);
    cmd_run_i = 1'b1;
    tick();
    cmd_run_i = 1'b0;
    expect_state("rerun", 3'd1);
    repeat (4) tick();
    expect_state("run_5", 3'd1);
    cmd_stop_i = 1'b1;
    halt_ex_i  = 1'b1;
    tick();
    cmd_stop_i = 1'b0;
    halt_ex_i  = 1'b0;
    expect_state("drain_1", 3'd3);
    tick();
    expect_state("drain_2", 3'd3);
    tick();
    expect_state("drain_3", 3'd3);
    tick();
    expect_state("halted", 3'd4);
    cmd_run_i = 1'b1;
    tick();
    cmd_run_i = 1'b0;
    expect_state("halted_ignores_run", 3'd4);
    cmd_step_i = 1'b1;
    tick();
    cmd_step_i = 1'b0;
    expect_state("halted_ignores_step", 3'd4);

    // halt seen during a step: drain, no step_done
    apply_reset();
    cmd_step_i = 1'b1;
    tick();
    cmd_step_i = 1'b0;
    expect_state("step_h", 3'd2);
    halt_ex_i = 1'b1;
    tick();
    halt_ex_i = 1'b0;
    expect_state("step_h_drain", 3'd3);
    chk("step_h_no_done", 32'(step_done), 32'd0);
    repeat (3) tick();
    expect_state("step_h_halted", 3'd4);

    // counter saturation on the 4-bit instance
    apply_reset();
    cmd_run_i = 1'b1;
    tick();
    cmd_run_i = 1'b0;
    expect_state("sat_run", 3'd1);
    repeat (10) tick();
    chk("cnt4_before_sat", 32'(cycle_count4), 32'(exp_cnt));
    repeat (10) tick();
    expect_state("sat_run_end", 3'd1);
    chk("cnt4_saturated", 32'(cycle_count4), 32'd15);
    tick();
    chk("cnt4_holds", 32'(cycle_count4), 32'd15);
    chk("state4_run", 32'(state4), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_run_controller.md
Name: pipeline_run_controller

Overview:
Drives `en_pipeline` and hazard controls into the IF/ID and ID/EX pipeline registers, and consumes the halt and memory-read signals those registers emit. It provides IDLE/RUN/STEP execution control for the debug unit, load-use stall/bubble generation, and a drain sequence once a halt instruction reaches EX. All logic is clocked on posedge so outputs are stable before the pipeline registers sample on negedge.

Parameters:
NB_REG, 5, register index width
NB_DATA, 32, cycle counter width
N_DRAIN, 3, cycles en_pipeline stays high after halt seen in EX (EX->MEM->WB retire)

Ports:
clock  in  1  system clock; state updates on posedge
reset_i  in  1  asynchronous, active-low reset
cmd_run_i  in  1  one-cycle pulse: free-run
cmd_step_i  in  1  one-cycle pulse: advance pipeline one cycle
cmd_stop_i  in  1  one-cycle pulse: pause free-run
halt_id_i  in  1  halt opcode decoded in ID
halt_ex_i  in  1  halt_signal_o from ID/EX register
ex_mem_read_i  in  1  memory-read bit of ID/EX mem_signals_o
ex_register_rw_i  in  NB_REG  ID/EX destination register
id_register_a_i  in  NB_REG  rs of instruction in ID
id_register_b_i  in  NB_REG  rt of instruction in ID
id_uses_rb_i  in  1  ID instruction reads rt
en_pipeline_o  out  1  global pipeline-register enable
stall_if_id_o  out  1  hold PC and IF/ID
bubble_id_ex_o  out  1  zero control fields into ID/EX
pc_hold_o  out  1  sticky: stop fetching after halt decoded
halted_o  out  1  program finished
step_done_o  out  1  one-cycle pulse after a step completes
state_o  out  3  current FSM state
cycle_count_o  out  NB_DATA  enabled-cycle count

Behaviour:
- Reset (reset_i=0, any time, including mid-DRAIN): state=IDLE. All outputs 0; drain counter 0; pc_hold cleared.
- States/encodings:
  - IDLE=0: en=0. cmd_run -> RUN; else cmd_step -> STEP. run wins if both are asserted.
  - RUN=1: en=1. halt_ex_i -> DRAIN with counter loaded to N_DRAIN-1. Else cmd_stop -> IDLE. halt beats stop. cmd_run/cmd_step are ignored.
  - STEP=2: en=1 for exactly this cycle. Next state IDLE with step_done_o=1 for one cycle. If halt_ex_i is high in STEP -> DRAIN instead, with no step_done.
  - DRAIN=3: en=1. Counter decrements each cycle; at 0 -> HALTED. All commands are ignored.
  - HALTED=4: en=0, halted_o=1. Only reset exits.
- en_pipeline_o, halted_o and state_o are registered (Moore). Latency from cmd pulse to en_pipeline_o=1 is one posedge.
- load_use = ex_mem_read_i & (ex_register_rw_i!=0) & (ex_register_rw_i==id_register_a_i | (id_uses_rb_i & ex_register_rw_i==id_register_b_i)).
- stall_if_id_o = bubble_id_ex_o = load_use & en_pipeline_o. This is combinational from registered state; both are 0 when en=0.
- pc_hold_o: set on posedge when halt_id_i & en_pipeline_o & !load_use. It stays set until reset.
- cycle_count_o: increments on each posedge where en_pipeline_o=1. It saturates at all-ones with no wrap.

Optional Feature:
PIPE_BREAKPOINT_EN. When defined, adds ports `bp_valid_i` (1), `bp_pc_i` (NB_DATA) and `id_pc_i` (NB_DATA).
- In RUN, bp_valid_i & id_pc_i==bp_pc_i -> IDLE next cycle.
- Priority: halt_ex_i > breakpoint > cmd_stop.
- A breakpoint does not fire in STEP, so the user can step off it.
When undefined, the ports and logic are absent and behaviour is exactly as above.

Decomposition:
- Shared package `pipeline_ctrl_pkg`:
  - state encodings IDLE..HALTED, the 3-bit state type
  - N_DRAIN default
  - the mem_signals bit index of memory-read
- One natural sub-module: `load_use_detector`, purely combinational, producing load_use.
- FSM, counters and pc_hold live in the top.

Test Plan:
- Reset low mid-RUN with cycle_count=7 -> all outputs 0, state_o=0 while low. After release, en stays 0 until cmd_run.
- cmd_step pulse in IDLE -> en_pipeline_o=1 for exactly 1 cycle. step_done_o pulses the following cycle. cycle_count 0->1.
- cmd_run, then halt_ex_i high 5 cycles later -> state RUN->DRAIN. en stays high 3 more cycles, then HALTED, halted_o=1. cmd_run is ignored afterwards.
- RUN with ex_mem_read_i=1, ex_rw=5, id_a=5 -> stall_if_id_o=bubble_id_ex_o=1 same cycle.
  - ex_rw=0 -> 0.
  - id_b=5 with id_uses_rb_i=0 -> 0.
- cmd_run and cmd_step in the same IDLE cycle -> RUN. cmd_stop and halt_ex_i in the same RUN cycle -> DRAIN.
- Force cycle_count to all-ones (NB_DATA=4 build) in RUN -> count holds at 15.
